// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one external add/sub datapath between two
// valid/ready requesters; one operation in flight, results returned to the winner.
module addsub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_m,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_m,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_ovf,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_ovf,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_m,
    input  logic [WIDTH-1:0] dp_sum,
    input  logic             dp_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

    state_t           state;
    state_t           state_next;
    logic             ptr;
    logic             owner;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_m;
    logic [WIDTH-1:0] res_sum;
    logic             res_ovf;
    logic             accept;
    logic             rsp_fire;

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                // The pointer only breaks ties; a lone requester always wins.
                req0_ready = req0_valid && (!req1_valid || !ptr);
                req1_ready = req1_valid && (!req0_valid || ptr);
                if (req0_ready || req1_ready) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = RESPOND;
            end
            RESPOND: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept   = req0_ready || req1_ready;
    assign rsp_fire = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_m    <= 1'b0;
            res_sum <= '0;
            res_ovf <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner <= req1_ready;
                op_a  <= req1_ready ? req1_a : req0_a;
                op_b  <= req1_ready ? req1_b : req0_b;
                op_m  <= req1_ready ? req1_m : req0_m;
            end
            if (state == ISSUE) begin
                res_sum <= dp_sum;
                res_ovf <= dp_ovf;
            end
            // Hand priority to the other requester once the owner is served.
            if (rsp_fire) begin
                ptr <= !owner;
            end
        end
    end

    assign dp_a     = op_a;
    assign dp_b     = op_b;
    assign dp_m     = op_m;
    assign rsp0_sum = res_sum;
    assign rsp1_sum = res_sum;
    assign rsp0_ovf = res_ovf;
    assign rsp1_ovf = res_ovf;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of the arbiter and signed arithmetic.
module tb_addsub_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_m;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_m;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp0_ovf;
    logic [W-1:0] rsp0_sum;
    logic         rsp1_valid, rsp1_ready, rsp1_ovf;
    logic [W-1:0] rsp1_sum;
    logic [W-1:0] dp_a, dp_b, dp_sum;
    logic         dp_m, dp_ovf, busy;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_sum(rsp0_sum), .rsp0_ovf(rsp0_ovf),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_sum(rsp1_sum), .rsp1_ovf(rsp1_ovf),
        .dp_a(dp_a), .dp_b(dp_b), .dp_m(dp_m),
        .dp_sum(dp_sum), .dp_ovf(dp_ovf),
        .busy(busy)
    );

    // External add/sub unit, expressed with sign-bit overflow rules.
    assign dp_sum = dp_m ? (dp_a - dp_b) : (dp_a + dp_b);
    assign dp_ovf = dp_m ? ((dp_a[W-1] ^ dp_b[W-1]) & (dp_sum[W-1] ^ dp_a[W-1]))
                         : (~(dp_a[W-1] ^ dp_b[W-1]) & (dp_sum[W-1] ^ dp_a[W-1]));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic on signed integers: overflow means out of range.
    function automatic void refResult(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                      output logic [W-1:0] s, output logic o);
        int sa, sb, r;
        sa = int'(a);
        sb = int'(b);
        if (a[W-1]) sa = sa - 256;
        if (b[W-1]) sb = sb - 256;
        r = m ? (sa - sb) : (sa + sb);
        o = (r > 127) || (r < -128);
        s = W'(r);
    endfunction

    // Model: at most one outstanding op, its owner, age in cycles and result.
    logic         m_busy = 1'b0, m_ptr = 1'b0, m_id = 1'b0, m_ovf = 1'b0, m_dpm = 1'b0;
    int           m_age = 0;
    logic [W-1:0] m_sum = '0, m_dpa = '0, m_dpb = '0;

    always @(negedge clk) begin : monitor
        int           win;
        logic [W-1:0] ma, mb;
        logic         mm;
        win = -1;
        if (!m_busy) begin
            if (req0_valid && req1_valid) win = m_ptr ? 1 : 0;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        if (mon_en) begin
            checkOutput("ready0", req0_ready, win == 0);
            checkOutput("ready1", req1_ready, win == 1);
            checkOutput("busy", busy, m_busy);
            checkOutput("rsp0_valid", rsp0_valid, m_busy && m_age >= 1 && !m_id);
            checkOutput("rsp1_valid", rsp1_valid, m_busy && m_age >= 1 && m_id);
            checkOutput("dp_a", dp_a, m_dpa);
            checkOutput("dp_b", dp_b, m_dpb);
            checkOutput("dp_m", dp_m, m_dpm);
            if (m_busy && m_age >= 1) begin
                checkOutput("rsp_sum", m_id ? rsp1_sum : rsp0_sum, m_sum);
                checkOutput("rsp_ovf", m_id ? rsp1_ovf : rsp0_ovf, m_ovf);
            end
        end
        if (rst) begin
            m_busy = 1'b0; m_ptr = 1'b0; m_age = 0;
            m_dpa = '0; m_dpb = '0; m_dpm = 1'b0;
        end else if (m_busy) begin
            if (m_age >= 1 && (m_id ? rsp1_ready : rsp0_ready)) begin
                m_busy = 1'b0;
                m_ptr  = !m_id;
            end else begin
                m_age++;
            end
        end else if (win >= 0) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_id   = (win == 1);
            ma = m_id ? req1_a : req0_a;
            mb = m_id ? req1_b : req0_b;
            mm = m_id ? req1_m : req0_m;
            refResult(ma, mb, mm, m_sum, m_ovf);
            m_dpa = ma; m_dpb = mb; m_dpm = mm;
        end
    end

    task automatic applyStimulus(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic m0,
                                 input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic m1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_m = m0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_m = m1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitRsp(input int id, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if ((id == 1 ? rsp1_valid : rsp0_valid) === 1'b1) break;
        end
        checkOutput($sformatf("rsp%0d_seen", id), id == 1 ? rsp1_valid : rsp0_valid, 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready0"}, req0_ready, 0);
        checkOutput({tag, "_ready1"}, req1_ready, 0);
        checkOutput({tag, "_rsp0_valid"}, rsp0_valid, 0);
        checkOutput({tag, "_rsp1_valid"}, rsp1_valid, 0);
        checkOutput({tag, "_rsp0_sum"}, rsp0_sum, 0);
        checkOutput({tag, "_rsp1_sum"}, rsp1_sum, 0);
        checkOutput({tag, "_rsp0_ovf"}, rsp0_ovf, 0);
        checkOutput({tag, "_rsp1_ovf"}, rsp1_ovf, 0);
        checkOutput({tag, "_dp_a"}, dp_a, 0);
        checkOutput({tag, "_dp_b"}, dp_b, 0);
        checkOutput({tag, "_dp_m"}, dp_m, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int grants[$];
        logic [W-1:0] s0, s1;
        logic o0, o1;
        bit got0, got1;

        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        checkAllZero("reset");

        // Single requester 0: -1 + 1 wraps to zero without overflow.
        step();
        rst = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        applyStimulus(1, 8'hFF, 8'h01, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("tp1_ready0", req0_ready, 1);
        checkOutput("tp1_ready1", req1_ready, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitRsp(0, lat);
        checkOutput("tp1_latency", lat, 2);
        checkOutput("tp1_sum", rsp0_sum, 8'h00);
        checkOutput("tp1_ovf", rsp0_ovf, 0);

        // Single requester 1: 127 + 1 overflows.
        step();
        applyStimulus(0, 0, 0, 0, 1, 8'h7F, 8'h01, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitRsp(1, lat);
        checkOutput("tp2_latency", lat, 2);
        checkOutput("tp2_sum", rsp1_sum, 8'h80);
        checkOutput("tp2_ovf", rsp1_ovf, 1);
        checkOutput("tp2_rsp0_idle", rsp0_valid, 0);

        // Both valid from reset: grants alternate starting with requester 0.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(1, 8'h80, 8'h01, 1, 1, 8'h6C, 8'hCA, 1);
        got0 = 0; got1 = 0; s0 = '0; s1 = '0; o0 = 0; o1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp0_valid && !got0) begin got0 = 1; s0 = rsp0_sum; o0 = rsp0_ovf; end
            if (rsp1_valid && !got1) begin got1 = 1; s1 = rsp1_sum; o1 = rsp1_ovf; end
        end
        checkOutput("tp3_ngrants", grants.size(), 4);
        for (int k = 0; k < grants.size(); k++)
            checkOutput($sformatf("tp3_grant%0d", k), grants[k], k % 2);
        checkOutput("tp3_sum0", s0, 8'h7F);
        checkOutput("tp3_ovf0", o0, 1);
        checkOutput("tp3_sum1", s1, 8'hA2);
        checkOutput("tp3_ovf1", o1, 1);

        // Backpressure on requester 0 with requester 1 waiting.
        step();
        rsp0_ready = 1'b0;
        applyStimulus(1, 8'h10, 8'h20, 0, 1, 8'h05, 8'h03, 0);
        @(negedge clk);
        checkOutput("tp4_grant0", req0_ready, 1);
        step();
        applyStimulus(0, 0, 0, 0, 1, 8'h05, 8'h03, 0);
        waitRsp(0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("tp4_hold_valid", rsp0_valid, 1);
            checkOutput("tp4_hold_sum", rsp0_sum, 8'h30);
            checkOutput("tp4_hold_ready1", req1_ready, 0);
            checkOutput("tp4_hold_busy", busy, 1);
        end
        step();
        rsp0_ready = 1'b1;
        @(negedge clk);
        checkOutput("tp4_last_hold_ready1", req1_ready, 0);
        @(negedge clk);
        checkOutput("tp4_req1_grant", req1_ready, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitRsp(1, lat);
        checkOutput("tp4_sum1", rsp1_sum, 8'h08);

        // Requester 0 changes operands while stalled behind requester 1.
        step();
        rsp1_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 8'h40, 8'h01, 0);
        step();
        applyStimulus(1, 8'h01, 8'h01, 0, 0, 0, 0, 0);
        waitRsp(1, lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("tp6_stall_ready0", req0_ready, 0);
        end
        step();
        applyStimulus(1, 8'h02, 8'h01, 0, 0, 0, 0, 0);
        step();
        rsp1_ready = 1'b1;
        waitRsp(0, lat);
        checkOutput("tp6_sum", rsp0_sum, 8'h03);
        checkOutput("tp6_ovf", rsp0_ovf, 0);

        // Reset while an operation is in ISSUE; pointer was 1 beforehand.
        step();
        applyStimulus(1, 8'h55, 8'hAA, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("tp5_issue_busy", busy, 1);
        @(negedge clk);
        checkAllZero("tp5");
        step();
        rst = 1'b0;
        applyStimulus(1, 8'h11, 8'h22, 0, 1, 8'h33, 8'h44, 1);
        @(negedge clk);
        checkOutput("tp5_ptr_ready0", req0_ready, 1);
        checkOutput("tp5_ptr_ready1", req1_ready, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();

        // Random traffic, checked by the monitor model.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst        = ($urandom_range(0, 99) == 0);
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
            applyStimulus($urandom_range(0, 9) < 6, randOperand(), randOperand(), 1'($urandom),
                          $urandom_range(0, 9) < 6, randOperand(), randOperand(), 1'($urandom));
        end
        step();
        rst = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Shares one combinational WIDTH-bit adder/subtractor (operands a, b, mode m, outputs sum and signed overflow ovf) between two requesters. Each requester uses valid/ready handshakes on request and response channels. The block arbitrates round-robin, registers the operands, drives the shared datapath, captures sum/ovf and returns them to the winning requester. It sits between the two client blocks and the single add/sub instance; the datapath is external and connects through the dp_* ports.

Parameters:
WIDTH, 8, operand/result width; must be >= 2

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle (when valid)
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_m  input  1  requester 0 mode: 0 = a+b, 1 = a-b
req1_valid / req1_ready / req1_a / req1_b / req1_m  same as requester 0, for requester 1
rsp0_valid  output  1  result available for requester 0
rsp0_ready  input  1  requester 0 takes the result
rsp0_sum  output  WIDTH  result for requester 0
rsp0_ovf  output  1  signed overflow for requester 0
rsp1_valid / rsp1_ready / rsp1_sum / rsp1_ovf  same as requester 0, for requester 1
dp_a  output  WIDTH  to shared datapath a
dp_b  output  WIDTH  to shared datapath b
dp_m  output  1  to shared datapath mode
dp_sum  input  WIDTH  from shared datapath, combinational
dp_ovf  input  1  from shared datapath, combinational
busy  output  1  high in any state except IDLE

Behaviour:
- FSM states: IDLE, ISSUE, RESPOND. One operation is in flight at a time.
- Reset (rst high at a clk edge):
  - state -> IDLE, priority pointer -> 0.
  - Operand, result and owner registers -> 0.
  - All outputs then read 0: ready, rsp_valid, rsp_sum, rsp_ovf, dp_a, dp_b, dp_m, busy.
  - Reset mid-operation drops the in-flight operation; no response is issued for it.
- IDLE:
  - reqN_ready is combinational and goes high only for the granted requester.
  - Grant rule: if only one valid, grant it. If both valid, grant the requester named by the pointer.
  - On the accept edge (valid & ready): latch a, b, m and the owner ID, then go to ISSUE.
  - At most one ready is high in any cycle. Both ready are 0 outside IDLE.
- ISSUE (exactly 1 cycle):
  - dp_a, dp_b, dp_m come from the operand registers.
  - At the cycle-end edge, latch dp_sum and dp_ovf into the result registers, then go to RESPOND.
- RESPOND:
  - rsp<owner>_valid is high with the registered sum/ovf. The other rsp_valid stays 0.
  - rsp_sum, rsp_ovf and dp_* stay stable until the handshake completes.
  - On the edge where rsp valid & ready: go to IDLE, and set the pointer to the non-owner (round-robin fairness).
  - rsp_ready low stalls the block indefinitely. While stalled, no new request is accepted.
- dp_a, dp_b, dp_m hold their last registered values in every state; they change only on accept.
- Latency: accept at edge T gives rsp_valid high in the cycle after edge T+1 (2 cycles). Minimum issue interval is 3 cycles with rsp_ready tied high.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Arithmetic is entirely in the external unit; the block does no computation. Results pass through unmodified: sum is modulo 2^WIDTH and ovf is signed two's-complement overflow.
- A requester may change its operands while not accepted. The accepted values are those present at the accept edge.
- rsp_ready asserted outside RESPOND has no effect.

Test Plan:
- After reset, with no requests: all outputs 0, state IDLE. Then req0 with a=8'hFF, b=8'h01, m=0 -> req0_ready high the same cycle, 2 cycles later rsp0_valid=1, rsp0_sum=8'h00, rsp0_ovf=0.
- req1 only, with a=8'h7F, b=8'h01, m=0 -> rsp1_sum=8'h80, rsp1_ovf=1. rsp0_valid stays 0 throughout.
- Both valid from reset: req0 a=8'h80, b=8'h01, m=1; req1 a=8'h6C, b=8'hCA, m=1.
  - req0 is granted first -> rsp0 8'h7F, ovf=1.
  - req1 is granted next -> rsp1 8'hA2, ovf=1.
  - Holding both valid, grants continue alternating 0,1,0,1.
- Backpressure: during RESPOND, hold rsp0_ready=0 for 5 cycles with req1_valid high -> rsp0 values stable, req1_ready stays 0, busy=1. Then release -> req1 is granted in the next IDLE cycle.
- Reset mid-operation: assert rst during ISSUE of a=8'h55, b=8'hAA, m=0 -> no rsp_valid for that operation, all outputs 0, pointer is 0 afterwards.
- Operand change: req0 shows a=8'h01 while stalled behind rsp1, then switches to a=8'h02, b=8'h01, m=0 before acceptance -> response is 8'h03, ovf=0.
